// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the architectural fetch PC, issues one instruction-memory request at a time
// and hands {instr, pc, prediction} to decode over a valid/ready handshake.
`timescale 1ns/1ps
module fetch_pc_unit #(
  parameter int                XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] bp_pc,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] fetch_pc,
  output logic            fetch_pred_taken,
  output logic [XLEN-1:0] fetch_pred_target
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] PC_INC = {{(XLEN-3){1'b0}}, 3'b100};

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

  state_t          r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_fetch_valid, w_fetch_valid_nxt;
  logic [31:0]     r_fetch_instr, w_fetch_instr_nxt;
  logic [XLEN-1:0] r_fetch_pc, w_fetch_pc_nxt;
  logic            r_pred_taken, w_pred_taken_nxt;
  logic [XLEN-1:0] r_pred_target, w_pred_target_nxt;
  logic            w_req_valid;
  logic            w_req_fire;

  // Request is suppressed while in reset so nothing escapes before the memory is up.
  assign w_req_valid       = rst_n & (r_state == ST_REQ) & ~redirect_valid;
  assign w_req_fire        = w_req_valid & imem_req_ready;

  assign bp_pc             = r_pc;
  assign imem_req_addr     = r_pc;
  assign imem_req_valid    = w_req_valid;
  assign fetch_valid       = r_fetch_valid;
  assign fetch_instr       = r_fetch_instr;
  assign fetch_pc          = r_fetch_pc;
  assign fetch_pred_taken  = r_pred_taken;
  assign fetch_pred_target = r_pred_target;

  // Next-state, next-PC and delivery-register logic; redirect overrides everything.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_fetch_valid_nxt = r_fetch_valid;
    w_fetch_instr_nxt = r_fetch_instr;
    w_fetch_pc_nxt    = r_fetch_pc;
    w_pred_taken_nxt  = r_pred_taken;
    w_pred_target_nxt = r_pred_target;
    if (redirect_valid) begin
      w_pc_nxt          = align_pc(redirect_pc);
      w_fetch_valid_nxt = 1'b0;
      case (r_state)
        ST_REQ:   w_state_nxt = ST_REQ;
        ST_VALID: w_state_nxt = ST_REQ;
        // An outstanding response still has to be swallowed before the next request.
        ST_WAIT:  w_state_nxt = imem_resp_valid ? ST_REQ : ST_DRAIN;
        ST_DRAIN: w_state_nxt = imem_resp_valid ? ST_REQ : ST_DRAIN;
        default:  w_state_nxt = ST_REQ;
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            w_fetch_pc_nxt    = r_pc;
            w_pred_taken_nxt  = bp_taken;
            w_pred_target_nxt = bp_target;
            w_pc_nxt          = bp_taken ? align_pc(bp_target) : (r_pc + PC_INC);
            w_state_nxt       = ST_WAIT;
          end else begin
            w_state_nxt = ST_REQ;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            w_fetch_instr_nxt = imem_resp_data;
            w_fetch_valid_nxt = 1'b1;
            w_state_nxt       = ST_VALID;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
        ST_VALID: begin
          if (fetch_ready) begin
            w_fetch_valid_nxt = 1'b0;
            w_state_nxt       = ST_REQ;
          end else begin
            w_state_nxt = ST_VALID;
          end
        end
        ST_DRAIN: begin
          if (imem_resp_valid) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end
        default: begin
          w_state_nxt       = ST_REQ;
          w_fetch_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  // State, PC and delivery registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_REQ;
      r_pc          <= align_pc(RESET_PC);
      r_fetch_valid <= 1'b0;
      r_fetch_instr <= 32'h0000_0000;
      r_fetch_pc    <= '0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_fetch_valid <= w_fetch_valid_nxt;
      r_fetch_instr <= w_fetch_instr_nxt;
      r_fetch_pc    <= w_fetch_pc_nxt;
      r_pred_taken  <= w_pred_taken_nxt;
      r_pred_target <= w_pred_target_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios followed by a randomized run
// checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_fetch_pc_unit;
  localparam int          XLEN   = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk, rst_n;
  logic [31:0] bp_pc, bp_target, imem_req_addr, imem_resp_data, redirect_pc;
  logic [31:0] fetch_instr, fetch_pc, fetch_pred_target;
  logic        bp_taken, imem_req_valid, imem_req_ready, imem_resp_valid;
  logic        redirect_valid, fetch_valid, fetch_ready, fetch_pred_taken;

  fetch_pc_unit #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .bp_pc(bp_pc), .bp_taken(bp_taken), .bp_target(bp_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .fetch_pred_taken(fetch_pred_taken), .fetch_pred_target(fetch_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instruction memory model: one outstanding request, fixed latency chosen at accept.
  logic        mem_pend = 1'b0;
  int          mem_cnt  = 0;
  int          mem_lat  = 1;
  logic [31:0] mem_addr = 32'h0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic drive_mem();
    imem_resp_valid = mem_pend && (mem_cnt == 0);
    imem_resp_data  = instr_of(mem_addr);
    #1;
  endtask

  task automatic advance();
    logic acc;
    acc = imem_req_valid && imem_req_ready;
    if (imem_resp_valid) mem_pend = 1'b0;
    if (acc) begin
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = mem_lat - 1;
    end else if (mem_pend && mem_cnt > 0) begin
      mem_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0700; imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b want 0", imem_req_valid); end
    checks++; if (fetch_valid !== 1'b0) begin errors++; $display("FAIL reset_fetch_valid got %b want 0", fetch_valid); end
    checks++; if (bp_pc !== RST_PC) begin errors++; $display("FAIL reset_bp_pc got %h want %h", bp_pc, RST_PC); end
    checks++; if ({fetch_instr, fetch_pc, fetch_pred_taken, fetch_pred_target} !== 97'h0) begin
      errors++; $display("FAIL reset_fetch_regs got %h %h %b %h want zeros", fetch_instr, fetch_pc, fetch_pred_taken, fetch_pred_target);
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b0; rst_n = 1'b1; mem_pend = 1'b0;
    @(posedge clk); #1;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      errors++; $display("FAIL reset_first_req got v=%b a=%h want v=1 a=%h", imem_req_valid, imem_req_addr, RST_PC);
    end
    advance();
  endtask

  task automatic test_sequential();
    mem_lat = 1; imem_req_ready = 1'b1; fetch_ready = 1'b1; bp_taken = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic [31:0] e;
      e = RST_PC + 32'(4 * (k / 3));
      drive_mem();
      checks++; if (fetch_valid !== ((k % 3) == 2)) begin
        errors++; $display("FAIL seq_fetch_valid cyc %0d got %b want %b", k, fetch_valid, ((k % 3) == 2));
      end
      if ((k % 3) == 0) begin
        checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== e) begin
          errors++; $display("FAIL seq_req cyc %0d got v=%b a=%h want v=1 a=%h", k, imem_req_valid, imem_req_addr, e);
        end
      end
      if ((k % 3) == 2) begin
        checks++; if (fetch_pc !== e || fetch_instr !== instr_of(e) || fetch_pred_taken !== 1'b0) begin
          errors++; $display("FAIL seq_fetch cyc %0d got pc=%h i=%h t=%b want pc=%h i=%h t=0", k, fetch_pc, fetch_instr, fetch_pred_taken, e, instr_of(e));
        end
      end
      advance();
    end
  endtask

  task automatic test_taken();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL redirect_blocks_req got %b want 0", imem_req_valid); end
    advance();
    redirect_valid = 1'b0; bp_taken = 1'b1; bp_target = 32'h0000_0080;
    drive_mem();
    checks++; if (bp_pc !== 32'h200 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
      errors++; $display("FAIL taken_req got bp=%h v=%b a=%h want bp=200 v=1 a=200", bp_pc, imem_req_valid, imem_req_addr);
    end
    advance();
    bp_taken = 1'b0; bp_target = 32'h0;
    drive_mem(); advance();
    drive_mem();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200 || fetch_pred_taken !== 1'b1 || fetch_pred_target !== 32'h80) begin
      errors++; $display("FAIL taken_fetch got v=%b pc=%h t=%b tg=%h want 1 200 1 80", fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target);
    end
    advance();
    imem_req_ready = 1'b0;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h80) begin
      errors++; $display("FAIL taken_next_req got v=%b a=%h want v=1 a=80", imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_stall();
    imem_req_ready = 1'b1; fetch_ready = 1'b0; mem_lat = 1;
    drive_mem(); advance();
    imem_req_ready = 1'b0;
    drive_mem(); advance();
    for (int k = 0; k < 5; k++) begin
      drive_mem();
      checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h80 || fetch_instr !== instr_of(32'h80) || imem_req_valid !== 1'b0) begin
        errors++; $display("FAIL stall_hold cyc %0d got v=%b pc=%h i=%h rq=%b want 1 80 %h 0", k, fetch_valid, fetch_pc, fetch_instr, imem_req_valid, instr_of(32'h80));
      end
      advance();
    end
    fetch_ready = 1'b1;
    drive_mem(); advance();
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h84 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release got rq=%b a=%h v=%b want 1 84 0", imem_req_valid, imem_req_addr, fetch_valid);
    end
    advance();
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1; mem_lat = 3;
    drive_mem(); advance();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0400;
    drive_mem(); advance();
    redirect_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive_mem();
      checks++; if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0) begin
        errors++; $display("FAIL drain cyc %0d got rq=%b v=%b want 0 0", k, imem_req_valid, fetch_valid);
      end
      advance();
    end
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h400 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL drain_done got rq=%b a=%h v=%b want 1 400 0", imem_req_valid, imem_req_addr, fetch_valid);
    end
    advance();
  endtask

  task automatic test_redirect_resp();
    imem_req_ready = 1'b1; mem_lat = 1;
    drive_mem(); advance();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0000_0500;
    drive_mem(); advance();
    redirect_valid = 1'b0;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500 || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL redir_resp got rq=%b a=%h v=%b want 1 500 0", imem_req_valid, imem_req_addr, fetch_valid);
    end
    advance();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0503;
    drive_mem(); advance();
    redirect_valid = 1'b0;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h500) begin
      errors++; $display("FAIL redir_align got rq=%b a=%h want 1 500", imem_req_valid, imem_req_addr);
    end
    advance();
  endtask

  task automatic test_wrap_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    drive_mem(); advance();
    redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_lat = 1; bp_taken = 1'b0; fetch_ready = 1'b1;
    drive_mem(); advance();
    imem_req_ready = 1'b0;
    drive_mem(); advance();
    drive_mem();
    checks++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_fetch got v=%b pc=%h want 1 fffffffc", fetch_valid, fetch_pc);
    end
    advance();
    imem_req_ready = 1'b1; mem_lat = 4;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_req got rq=%b a=%h want 1 0", imem_req_valid, imem_req_addr);
    end
    advance();
    imem_req_ready = 1'b0;
    rst_n = 1'b0; mem_pend = 1'b0; imem_resp_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0 || fetch_valid !== 1'b0 || bp_pc !== RST_PC) begin
      errors++; $display("FAIL async_reset got rq=%b v=%b pc=%h want 0 0 %h", imem_req_valid, fetch_valid, bp_pc, RST_PC);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_mem();
    checks++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || fetch_valid !== 1'b0) begin
      errors++; $display("FAIL post_reset_req got rq=%b a=%h v=%b want 1 %h 0", imem_req_valid, imem_req_addr, fetch_valid, RST_PC);
    end
    advance();
  endtask

  task automatic test_random(input int n);
    logic [31:0] exp_pc, inf_pc, inf_tgt, h_pc, h_tgt, h_instr;
    logic        inf_live, inf_tk, h_v, h_tk, exp_req;
    int          delivered;
    exp_pc = RST_PC; inf_live = 1'b0; h_v = 1'b0; delivered = 0;
    inf_pc = 32'h0; inf_tgt = 32'h0; inf_tk = 1'b0; h_pc = 32'h0; h_tgt = 32'h0; h_instr = 32'h0; h_tk = 1'b0;
    for (int c = 0; c < n; c++) begin
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      bp_taken       = 1'($urandom_range(1));
      bp_target      = $urandom;
      imem_req_ready = ($urandom_range(3) != 0);
      fetch_ready    = 1'($urandom_range(1));
      mem_lat        = int'($urandom_range(4, 1));
      drive_mem();
      exp_req = !mem_pend && !h_v && !redirect_valid;
      checks++; if (imem_req_valid !== exp_req) begin
        errors++; $display("FAIL rnd_req_valid cyc %0d got %b want %b", c, imem_req_valid, exp_req);
      end
      if (exp_req) begin
        checks++; if (imem_req_addr !== exp_pc || bp_pc !== exp_pc) begin
          errors++; $display("FAIL rnd_req_addr cyc %0d got a=%h bp=%h want %h", c, imem_req_addr, bp_pc, exp_pc);
        end
      end
      checks++; if (fetch_valid !== h_v) begin
        errors++; $display("FAIL rnd_fetch_valid cyc %0d got %b want %b", c, fetch_valid, h_v);
      end
      if (h_v) begin
        checks++; if (fetch_pc !== h_pc || fetch_instr !== h_instr || fetch_pred_taken !== h_tk || fetch_pred_target !== h_tgt) begin
          errors++; $display("FAIL rnd_fetch_data cyc %0d got %h %h %b %h want %h %h %b %h", c, fetch_pc, fetch_instr, fetch_pred_taken, fetch_pred_target, h_pc, h_instr, h_tk, h_tgt);
        end
      end
      // Transaction-level effect of this cycle.
      if (redirect_valid) begin
        exp_pc = {redirect_pc[31:2], 2'b00}; h_v = 1'b0; inf_live = 1'b0;
      end else begin
        if (h_v && fetch_ready) begin h_v = 1'b0; delivered++; end
        if (imem_resp_valid && inf_live) begin
          h_v = 1'b1; h_pc = inf_pc; h_tk = inf_tk; h_tgt = inf_tgt; h_instr = imem_resp_data; inf_live = 1'b0;
        end
        if (exp_req && imem_req_ready) begin
          inf_live = 1'b1; inf_pc = exp_pc; inf_tk = bp_taken; inf_tgt = bp_target;
          exp_pc = bp_taken ? {bp_target[31:2], 2'b00} : exp_pc + 32'd4;
        end
      end
      advance();
    end
    checks++; if (delivered < 20) begin
      errors++; $display("FAIL rnd_throughput got %0d deliveries want >= 20", delivered);
    end
  endtask

  initial begin
    rst_n = 1'b0; bp_taken = 1'b0; bp_target = 32'h0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; fetch_ready = 1'b0;
    test_reset();
    test_sequential();
    test_taken();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_wrap_reset();
    test_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
